// File: rtl/bit_serial_multiplier_ctrl_if.sv
// Operand/product handshake bundle for the bit-serial multiplier sequencer.
//   in_valid/in_ready : operand handshake carrying a, b (W bits each, unsigned)
//   out_valid/out_ready : product handshake carrying product (2W bits)
// master = operand producer / product consumer; slave = the sequencer.
interface bit_serial_multiplier_ctrl_if #(
   parameter int unsigned W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   product;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/bit_serial_multiplier_ctrl.sv
// Sequencer for the W-slice bit-serial multiplier array.
// Accepts parallel operands, streams them LSB-first into slice 0 together with the r_in token
// and the array clear, then deserialises the 2W-bit product coming back on p_bit.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   bus          : operand/product valid-ready handshake (slave side)
//   x_bit, y_bit : serial operands to slice 0; xy_bit = x_bit & y_bit
//   r_tok        : r_in token to slice 0, high on the first serial cycle
//   last_bit     : array clear to every slice (FLUSH and the final serial cycle)
//   p_bit        : serial product bit from slice 0 p_out
module bit_serial_multiplier_ctrl #(
   parameter int unsigned W        = 8,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   bit_serial_multiplier_ctrl_if.slave  bus,
   output logic                         x_bit,
   output logic                         y_bit,
   output logic                         xy_bit,
   output logic                         r_tok,
   output logic                         last_bit,
   input  logic                         p_bit
);

   localparam int unsigned N    = 2 * W + PIPE_LAT;
   localparam int unsigned CntW = $clog2(N + 1);

   typedef logic [CntW-1:0] cnt_t;
   localparam cnt_t CntLast = cnt_t'(N - 1);
   localparam cnt_t CntCap  = cnt_t'(PIPE_LAT);

   typedef enum logic [1:0] {StFlush, StIdle, StRun, StHold} state_e;

   state_e           state_q, state_d;
   cnt_t             cnt_q, cnt_d;
   logic [W-1:0]     a_sh_q, a_sh_d;
   logic [W-1:0]     b_sh_q, b_sh_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic             in_ready_c;
   logic             out_valid_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFlush;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      prod_d      = prod_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      x_bit       = 1'b0;
      y_bit       = 1'b0;
      r_tok       = 1'b0;
      last_bit    = 1'b0;

      unique case (state_q)
         // One cycle of clear for the array's non-reset flops.
         StFlush: begin
            last_bit = 1'b1;
            state_d  = StIdle;
         end

         StIdle: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               cnt_d   = '0;
               prod_d  = '0;
               state_d = StRun;
            end
         end

         StRun: begin
            x_bit    = a_sh_q[0];
            y_bit    = b_sh_q[0];
            // Zero fill supplies the 0 operand bits for k >= W.
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            r_tok    = (cnt_q == '0);
            last_bit = (cnt_q == CntLast);
            // First product bit arrives PIPE_LAT cycles in; 2W right shifts land it in bit 0.
            if (cnt_q >= CntCap) begin
               prod_d = {p_bit, prod_q[2*W-1:1]};
            end
            if (cnt_q == CntLast) begin
               state_d = StHold;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end

         StHold: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StFlush;
         end
      endcase
   end

   assign xy_bit        = x_bit & y_bit;
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.product   = prod_q;

endmodule

// File: tb/tb_bit_serial_multiplier_ctrl.sv
// Bench for bit_serial_multiplier_ctrl: instance 0 with PIPE_LAT=1, instance 1 with PIPE_LAT=2.
// Each instance drives a behavioural model of the bit-serial array that returns product bit k
// PIPE_LAT cycles after operand bit k entered slice 0.
module tb_bit_serial_multiplier_ctrl;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   bit_serial_multiplier_ctrl_if #(.W(W)) ifc0 ();
   bit_serial_multiplier_ctrl_if #(.W(W)) ifc1 ();

   logic x_b[2], y_b[2], xy_b[2], rt[2], lb[2], p_b[2];

   logic           in_valid_d[2], out_ready_d[2];
   logic [W-1:0]   a_d[2], b_d[2];
   logic           in_ready_s[2], out_valid_s[2];
   logic [2*W-1:0] prod_s[2];

   assign ifc0.in_valid  = in_valid_d[0];
   assign ifc0.a         = a_d[0];
   assign ifc0.b         = b_d[0];
   assign ifc0.out_ready = out_ready_d[0];
   assign ifc1.in_valid  = in_valid_d[1];
   assign ifc1.a         = a_d[1];
   assign ifc1.b         = b_d[1];
   assign ifc1.out_ready = out_ready_d[1];
   assign in_ready_s[0]  = ifc0.in_ready;
   assign out_valid_s[0] = ifc0.out_valid;
   assign prod_s[0]      = ifc0.product;
   assign in_ready_s[1]  = ifc1.in_ready;
   assign out_valid_s[1] = ifc1.out_valid;
   assign prod_s[1]      = ifc1.product;

   bit_serial_multiplier_ctrl #(.W(W), .PIPE_LAT(1)) dut0 (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (ifc0.slave),
      .x_bit    (x_b[0]),
      .y_bit    (y_b[0]),
      .xy_bit   (xy_b[0]),
      .r_tok    (rt[0]),
      .last_bit (lb[0]),
      .p_bit    (p_b[0])
   );

   bit_serial_multiplier_ctrl #(.W(W), .PIPE_LAT(2)) dut1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (ifc1.slave),
      .x_bit    (x_b[1]),
      .y_bit    (y_b[1]),
      .xy_bit   (xy_b[1]),
      .r_tok    (rt[1]),
      .last_bit (lb[1]),
      .p_bit    (p_b[1])
   );

   // Array model: accumulate serial operand bits, emit product bit k, delay it by PIPE_LAT.
   logic [2*W-1:0] xa[2], ya[2], xn[2], yn[2], pr[2];
   int             k[2], kn[2];
   logic           bn[2];
   logic [3:0]     dly[2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         kn[i] = rt[i] ? 0 : k[i];
         xn[i] = rt[i] ? '0 : xa[i];
         yn[i] = rt[i] ? '0 : ya[i];
         bn[i] = 1'b0;
         pr[i] = '0;
         if (kn[i] < 2 * W) begin
            xn[i][kn[i][3:0]] = x_b[i];
            yn[i][kn[i][3:0]] = y_b[i];
            pr[i] = xn[i] * yn[i];
            bn[i] = pr[i][kn[i][3:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            xa[i]  <= '0;
            ya[i]  <= '0;
            k[i]   <= 0;
            dly[i] <= '0;
         end else begin
            xa[i]  <= xn[i];
            ya[i]  <= yn[i];
            k[i]   <= (kn[i] < 1000) ? kn[i] + 1 : kn[i];
            dly[i] <= {dly[i][2:0], bn[i]};
         end
      end
   end

   assign p_b[0] = dly[0][0];
   assign p_b[1] = dly[1][1];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb[$];
   bit          busy = 1'b0;
   int          cyc = 0;
   int          last_acc = 0;
   int          acc_gap = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard for instance 0: push a*b on accept, pop on product handshake.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int s = 0; s < 2; s++) check_eq("xy_bit", 32'(xy_b[s]), 32'(x_b[s] & y_b[s]));
         if (!reset_n) begin
            sb.delete();
            busy = 1'b0;
         end else begin
            if (busy) check_eq("ready_while_busy", 32'(in_ready_s[0]), 32'd0);
            if (out_valid_s[0] && out_ready_d[0]) begin
               if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
               else check_eq("sb_product", 32'(prod_s[0]), sb.pop_front());
               busy = 1'b0;
            end
            if (in_valid_d[0] && in_ready_s[0]) begin
               sb.push_back(32'(a_d[0]) * 32'(b_d[0]));
               busy     = 1'b1;
               acc_gap  = cyc - last_acc;
               last_acc = cyc;
            end
         end
      end
   end

   // One directed operation: records token/clear timing, then holds out_ready low for hold cycles.
   task automatic run_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input logic [31:0] exp, output int lat,
                         output int rt_at, output int lb_at, output int rt_n, output int lb_n);
      int guard = 0;
      while (!in_ready_s[s] && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check_eq("op_ready", 32'(guard < 200), 32'd1);
      in_valid_d[s] = 1'b1;
      a_d[s] = a;
      b_d[s] = b;
      @(posedge clk); #1;
      in_valid_d[s] = 1'b0;
      lat = 1; rt_at = 0; lb_at = 0; rt_n = 0; lb_n = 0;
      while (!out_valid_s[s] && lat < 100) begin
         if (rt[s]) begin rt_n++; rt_at = lat; end
         if (lb[s]) begin lb_n++; lb_at = lat; end
         @(posedge clk); #1;
         lat++;
      end
      check_eq("product", 32'(prod_s[s]), exp);
      for (int h = 0; h < hold; h++) begin
         if (h == 0) begin
            in_valid_d[s] = 1'b1;
            a_d[s] = 8'hA5;
            b_d[s] = 8'h3C;
         end
         @(posedge clk); #1;
         check_eq("hold_product", 32'(prod_s[s]), exp);
         check_eq("hold_in_ready", 32'(in_ready_s[s]), 32'd0);
         check_eq("hold_out_valid", 32'(out_valid_s[s]), 32'd1);
      end
      in_valid_d[s]  = 1'b0;
      out_ready_d[s] = 1'b1;
      @(posedge clk); #1;
      out_ready_d[s] = 1'b0;
      check_eq("out_valid_fall", 32'(out_valid_s[s]), 32'd0);
      check_eq("in_ready_back", 32'(in_ready_s[s]), 32'd1);
   endtask

   // Present operands on instance 0 until accepted; optionally randomise out_ready each cycle.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
      bit acc = 1'b0;
      int guard = 0;
      in_valid_d[0] = 1'b1;
      a_d[0] = a;
      b_d[0] = b;
      do begin
         @(negedge clk);
         acc = in_ready_s[0];
         @(posedge clk); #1;
         if (rnd) out_ready_d[0] = ($urandom_range(0, 3) != 0);
         guard++;
      end while (!acc && guard < 500);
      in_valid_d[0] = 1'b0;
      if (!acc) check_eq("send_accept", 32'(acc), 32'd1);
   endtask

   int lat, rt_at, lb_at, rt_n, lb_n, guard;

   initial begin
      for (int s = 0; s < 2; s++) begin
         in_valid_d[s]  = 1'b0;
         out_ready_d[s] = 1'b0;
         a_d[s] = '0;
         b_d[s] = '0;
      end
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_eq("rst_in_ready", 32'(in_ready_s[s]), 32'd0);
         check_eq("rst_out_valid", 32'(out_valid_s[s]), 32'd0);
         check_eq("rst_product", 32'(prod_s[s]), 32'd0);
         check_eq("rst_serial", 32'({x_b[s], y_b[s], xy_b[s], rt[s]}), 32'd0);
         check_eq("rst_last_bit", 32'(lb[s]), 32'd1);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_eq("flush_last_bit", 32'(lb[0]), 32'd1);
      check_eq("flush_in_ready", 32'(in_ready_s[0]), 32'd0);
      @(posedge clk); #1;
      check_eq("idle_in_ready", 32'(in_ready_s[0]), 32'd1);
      check_eq("idle_last_bit", 32'(lb[0]), 32'd0);

      run_op(0, 8'd13, 8'd11, 5, 32'd143, lat, rt_at, lb_at, rt_n, lb_n);
      check_eq("latency_l1", 32'(lat), 32'(2 * W + 1 + 1));
      check_eq("r_tok_count", 32'(rt_n), 32'd1);
      check_eq("r_tok_pos", 32'(rt_at), 32'd1);
      check_eq("last_bit_count", 32'(lb_n), 32'd1);
      check_eq("last_bit_pos", 32'(lb_at), 32'd17);
      run_op(0, 8'd255, 8'd255, 0, 32'd65025, lat, rt_at, lb_at, rt_n, lb_n);
      run_op(0, 8'd0, 8'd200, 0, 32'd0, lat, rt_at, lb_at, rt_n, lb_n);
      check_eq("latency_zero_op", 32'(lat), 32'd18);
      run_op(0, 8'd1, 8'd1, 0, 32'd1, lat, rt_at, lb_at, rt_n, lb_n);

      run_op(1, 8'd200, 8'd3, 2, 32'd600, lat, rt_at, lb_at, rt_n, lb_n);
      check_eq("latency_l2", 32'(lat), 32'(2 * W + 2 + 1));
      check_eq("tok_clear_spacing_l2", 32'(lb_at - rt_at), 32'd17);
      check_eq("r_tok_count_l2", 32'(rt_n), 32'd1);
      check_eq("last_bit_count_l2", 32'(lb_n), 32'd1);

      // Abort 100*100 at cnt==6.
      in_valid_d[0] = 1'b1;
      a_d[0] = 8'd100;
      b_d[0] = 8'd100;
      @(posedge clk); #1;
      in_valid_d[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_eq("mid_run_no_tok", 32'(rt[0]), 32'd0);
      reset_n = 1'b0;
      #1;
      check_eq("abort_serial", 32'({x_b[0], y_b[0], xy_b[0], rt[0]}), 32'd0);
      check_eq("abort_handshake", 32'({in_ready_s[0], out_valid_s[0]}), 32'd0);
      check_eq("abort_product", 32'(prod_s[0]), 32'd0);
      check_eq("abort_last_bit", 32'(lb[0]), 32'd1);
      @(posedge clk);
      @(negedge clk); #1;
      reset_n = 1'b1;
      #1;
      check_eq("abort_flush_last_bit", 32'(lb[0]), 32'd1);
      check_eq("abort_flush_ready", 32'(in_ready_s[0]), 32'd0);
      run_op(0, 8'd7, 8'd9, 0, 32'd63, lat, rt_at, lb_at, rt_n, lb_n);

      // Back-to-back with the consumer always ready.
      out_ready_d[0] = 1'b1;
      send(8'd3, 8'd5, 1'b0);
      send(8'd17, 8'd19, 1'b0);
      send(8'd250, 8'd2, 1'b0);
      check_eq("b2b_interval", 32'(acc_gap), 32'(2 * W + 1 + 2));

      for (int i = 0; i < 1000; i++) begin
         send(W'($urandom), W'($urandom), 1'b1);
      end

      in_valid_d[0]  = 1'b0;
      out_ready_d[0] = 1'b1;
      guard = 0;
      while ((sb.size() != 0) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check_eq("drain_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
